synch_fifo: RTL and testbench



---
 rtl/synch_fifo.sv | 103 ++++++++++
 tb/tb_synch_fifo.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/synch_fifo.sv
// Single-clock FIFO with registered read port and output-valid flag.
// Define SYNCH_FIFO_ERR_EN to add sticky overflow/underflow outputs.
module synch_fifo #(
  parameter int DEPTH      = 512,
  parameter int DATA_WIDTH = 43
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  w_en,
  input  logic                  r_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid,
  output logic                  empty,
  output logic                  full
`ifdef SYNCH_FIFO_ERR_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_valid;

  logic                  w_wr;
  logic                  w_rd;
  logic [PW-1:0]         w_wptr_next;
  logic [PW-1:0]         w_rptr_next;

  assign empty    = (r_count == '0);
  assign full     = (r_count == CW'(DEPTH));
  assign w_wr     = w_en && !full;
  assign w_rd     = r_en && !empty;
  assign data_out = r_data_out;
  assign valid    = r_valid;

  // Explicit wrap so non-power-of-two depths work.
  assign w_wptr_next = (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + PW'(1);
  assign w_rptr_next = (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + PW'(1);

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_data_out <= '0;
      r_valid    <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wptr <= w_wptr_next;
      end
      if (w_rd) begin
        r_rptr     <= w_rptr_next;
        r_data_out <= r_mem[r_rptr];
        r_valid    <= 1'b1;
      end else if (r_en) begin
        r_valid <= 1'b0;
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef SYNCH_FIFO_ERR_EN
  logic r_overflow;
  logic r_underflow;

  assign overflow  = r_overflow;
  assign underflow = r_underflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_en && full) begin
        r_overflow <= 1'b1;
      end
      if (r_en && empty) begin
        r_underflow <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_synch_fifo.sv
// Randomized + directed bench for synch_fifo against a queue-based reference model.
module tb_synch_fifo;

  localparam int DEPTH = 4;
  localparam int DW    = 8;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          w_en    = 1'b0;
  logic          r_en    = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          valid;
  logic          empty;
  logic          full;
`ifdef SYNCH_FIFO_ERR_EN
  logic          overflow;
  logic          underflow;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [DW-1:0] mq[$];
  logic [DW-1:0] mDout  = '0;
  logic          mValid = 1'b0;
  logic          mOvf   = 1'b0;
  logic          mUnf   = 1'b0;

  synch_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .w_en     (w_en),
    .r_en     (r_en),
    .data_out (data_out),
    .valid    (valid),
    .empty    (empty),
    .full     (full)
`ifdef SYNCH_FIFO_ERR_EN
    ,
    .overflow (overflow),
    .underflow(underflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".data_out"}, 32'(data_out), 32'(mDout));
    checkOutput({tag, ".valid"}, 32'(valid), 32'(mValid));
    checkOutput({tag, ".empty"}, 32'(empty), 32'(mq.size() == 0));
    checkOutput({tag, ".full"}, 32'(full), 32'(mq.size() == DEPTH));
`ifdef SYNCH_FIFO_ERR_EN
    checkOutput({tag, ".overflow"}, 32'(overflow), 32'(mOvf));
    checkOutput({tag, ".underflow"}, 32'(underflow), 32'(mUnf));
`endif
  endtask

  // One clock of stimulus; the model advances from the pre-edge occupancy.
  task automatic applyStimulus(input logic w, input logic r, input logic [DW-1:0] d, input string tag);
    bit wasFull;
    bit wasEmpty;
    @(negedge clk);
    w_en    = w;
    r_en    = r;
    data_in = d;
    @(posedge clk);
    wasFull  = (mq.size() == DEPTH);
    wasEmpty = (mq.size() == 0);
    if (w && wasFull) mOvf = 1'b1;
    if (r && wasEmpty) mUnf = 1'b1;
    if (r && !wasEmpty) begin
      mDout  = mq.pop_front();
      mValid = 1'b1;
    end else if (r) begin
      mValid = 1'b0;
    end
    if (w && !wasFull) mq.push_back(d);
    #1;
    checkAll(tag);
  endtask

  task automatic midCycleReset(input string tag);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    mq.delete();
    mDout  = '0;
    mValid = 1'b0;
    mOvf   = 1'b0;
    mUnf   = 1'b0;
    #1;
    checkOutput({tag, ".empty_now"}, 32'(empty), 32'd1);
    checkOutput({tag, ".full_now"}, 32'(full), 32'd0);
    checkOutput({tag, ".valid_now"}, 32'(valid), 32'd0);
    checkOutput({tag, ".dout_now"}, 32'(data_out), 32'd0);
    checkAll(tag);
    @(negedge clk);
    w_en  = 1'b0;
    r_en  = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] simExp [6];
    #2;
    checkOutput("por.empty", 32'(empty), 32'd1);
    checkOutput("por.valid", 32'(valid), 32'd0);
    checkOutput("por.dout", 32'(data_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic ordering
    applyStimulus(1, 0, 8'h11, "ord.w");
    applyStimulus(1, 0, 8'h22, "ord.w");
    applyStimulus(1, 0, 8'h33, "ord.w");
    applyStimulus(0, 1, 8'h00, "ord.r");
    checkOutput("ord.first", 32'(data_out), 32'h11);
    applyStimulus(0, 1, 8'h00, "ord.r");
    checkOutput("ord.second", 32'(data_out), 32'h22);
    applyStimulus(0, 1, 8'h00, "ord.r");
    checkOutput("ord.third", 32'(data_out), 32'h33);
    checkOutput("ord.valid", 32'(valid), 32'd1);
    checkOutput("ord.empty", 32'(empty), 32'd1);

    // Mid-operation reset with entries queued
    applyStimulus(1, 0, 8'h99, "pre.w");
    applyStimulus(0, 1, 8'h00, "pre.r");
    applyStimulus(1, 0, 8'h98, "pre.w");
    midCycleReset("rst1");

    // Full and overflow
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 0, DW'(8'hA0 + i), "full.w");
      if (i == 3) checkOutput("full.after4", 32'(full), 32'd1);
    end
`ifdef SYNCH_FIFO_ERR_EN
    checkOutput("full.ovf", 32'(overflow), 32'd1);
`endif
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 8'h00, "full.r");
      checkOutput("full.rdata", 32'(data_out), 32'(8'hA0 + i));
    end

    // Read while empty keeps data, drops valid
    applyStimulus(0, 1, 8'h00, "emp.r");
    checkOutput("emp.valid", 32'(valid), 32'd0);
    checkOutput("emp.dout", 32'(data_out), 32'hA3);
`ifdef SYNCH_FIFO_ERR_EN
    checkOutput("emp.unf", 32'(underflow), 32'd1);
    checkOutput("emp.ovf_sticky", 32'(overflow), 32'd1);
`endif

    // Simultaneous read/write across pointer wrap
    applyStimulus(1, 0, 8'h60, "sim.pre");
    applyStimulus(1, 0, 8'h61, "sim.pre");
    simExp = '{8'h60, 8'h61, 8'h50, 8'h51, 8'h52, 8'h53};
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 1, DW'(8'h50 + i), "sim.rw");
      checkOutput("sim.rdata", 32'(data_out), 32'(simExp[i]));
      checkOutput("sim.valid", 32'(valid), 32'd1);
      checkOutput("sim.occ", 32'(mq.size()), 32'd2);
    end

    // Write+read while empty: no bypass
    midCycleReset("rst2");
    applyStimulus(1, 1, 8'h77, "eb.rw");
    checkOutput("eb.valid", 32'(valid), 32'd0);
    checkOutput("eb.empty", 32'(empty), 32'd0);
    applyStimulus(0, 1, 8'h00, "eb.r");
    checkOutput("eb.rdata", 32'(data_out), 32'h77);
    checkOutput("eb.valid2", 32'(valid), 32'd1);

    // Randomized traffic with an occasional reset
    for (int n = 0; n < 600; n++) begin
      if (n == 300) midCycleReset("rst3");
      applyStimulus(logic'($urandom_range(0, 99) < 55),
                    logic'($urandom_range(0, 99) < 50),
                    DW'($urandom), "rnd");
    end

    @(negedge clk);
    w_en = 1'b0;
    r_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
